sha256_compress_engine: RTL

//  Consumer end of the SHA-256 message-schedule stream. Accepts 64 schedule words W[0..63] over a

---
 rtl/sha256_compress_engine_pkg.sv | 46 ++++
 rtl/sha256_compress_engine_round.sv | 22 ++
 rtl/sha256_compress_engine.sv | 104 ++++++++++
 3 files changed

// File: rtl/sha256_compress_engine_pkg.sv
// Shared SHA-256 definitions: word/hash types, round constants, IV and the
// upper-sigma / choose / majority functions used by the compression round.
package sha256_compress_engine_pkg;

    typedef logic [0:31]      word_t;
    typedef logic [0:7][0:31] hash_t;  // element 0 is a / H0, in the top bits

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_e;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam hash_t SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t big_s0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_s1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_compress_engine_round.sv
// One SHA-256 compression round, purely combinational: a..h, K[t], W[t] in,
// next a..h out.
module sha256_round
    import sha256_compress_engine_pkg::*;
(
    input  hash_t regs_in,
    input  word_t k,
    input  word_t w,
    output hash_t regs_out
);

    word_t t1;
    word_t t2;

    always_comb begin
        t1 = regs_in[7] + big_s1(regs_in[4]) + ch(regs_in[4], regs_in[5], regs_in[6]) + k + w;
        t2 = big_s0(regs_in[0]) + maj(regs_in[0], regs_in[1], regs_in[2]);
        regs_out = {t1 + t2, regs_in[0], regs_in[1], regs_in[2],
                    regs_in[3] + t1, regs_in[4], regs_in[5], regs_in[6]};
    end

endmodule

// File: rtl/sha256_compress_engine.sv
// SHA-256 compression engine: consumes 64 schedule words over valid/ready,
// one round per accepted word, then presents chain + a..h as the digest.
module sha256_compress_engine
    import sha256_compress_engine_pkg::*;
#(
    parameter int NUM_ROUNDS = 64,
    parameter bit OUT_REG    = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         use_iv,
    input  logic [0:255] chain_in,
    input  logic         w_valid,
    input  logic [0:31]  w_data,
    output logic         w_ready,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [0:255] digest,
    output logic         busy
);

    localparam logic [6:0] LAST_RND = 7'(NUM_ROUNDS - 1);

    state_e     state_q, state_d;
    hash_t      regs_q, regs_d;
    hash_t      chain_q, chain_d;
    logic [6:0] round_cnt_q, round_cnt_d;
    hash_t      round_out;
    hash_t      sum;

    sha256_round u_round (
        .regs_in  (regs_q),
        .k        (K[round_cnt_q[5:0]]),
        .w        (w_data),
        .regs_out (round_out)
    );

    always_comb begin
        for (int i = 0; i < 8; i++) sum[i] = chain_q[i] + regs_q[i];
    end

    // Outputs depend on state only, so no path from w_valid/digest_ready.
    assign w_ready      = (state_q == ROUND);
    assign digest_valid = (state_q == DONE);
    assign busy         = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        chain_d     = chain_q;
        round_cnt_d = round_cnt_q;
        case (state_q)
            IDLE: if (start) begin
                // chain source is sampled together with start
                chain_d = use_iv ? SHA256_IV : chain_in;
                state_d = LOAD;
            end
            LOAD: begin
                regs_d      = chain_q;
                round_cnt_d = '0;
                state_d     = ROUND;
            end
            ROUND: if (w_valid) begin
                regs_d      = round_out;
                round_cnt_d = round_cnt_q + 7'd1;
                if (round_cnt_q == LAST_RND) state_d = FINAL;
            end
            FINAL: state_d = DONE;
            DONE:  if (digest_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            regs_q      <= '0;
            chain_q     <= '0;
            round_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            chain_q     <= chain_d;
            round_cnt_q <= round_cnt_d;
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            hash_t hout_q, hout_d;
            always_comb hout_d = (state_q == FINAL) ? sum : hout_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) hout_q <= '0;
                else        hout_q <= hout_d;
            end
            assign digest = hout_q;
        end else begin : g_out_comb
            // a..h and chain hold after FINAL, so the adder output is stable in DONE
            assign digest = sum;
        end
    endgenerate

endmodule
